dice_game_ctrl: RTL and testbench

DICE_GAME_CTRL -- requirements
Module: dice_game_ctrl

---
 rtl/dice_pkg.sv | 14 +
 rtl/dice_rng.sv | 25 ++
 rtl/dice_game_ctrl.sv | 112 +++++++++++
 tb/tb_dice_game_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// Shared types and constants for the two-player dice game controller.
package dice_pkg;
    localparam int DIE_W = 3;
    localparam logic [3:0] WIN_SCORE_DEFAULT = 4'd9;
    localparam logic [DIE_W-1:0] DIE_MIN = 3'd1;
    localparam logic [DIE_W-1:0] DIE_MAX = 3'd6;

    typedef enum logic [1:0] {
        WAIT_P1,
        WAIT_P2,
        EVAL,
        OVER
    } state_e;
endpackage

// File: rtl/dice_rng.sv
// Free-running die source: cycles 1..6 every clock, restarts at 1 on reset.
module dice_rng
    import dice_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    output logic [DIE_W-1:0] value
);
    logic [DIE_W-1:0] value_q;
    logic [DIE_W-1:0] value_d;

    always_comb begin
        value_d = (value_q == DIE_MAX) ? DIE_MIN : value_q + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= DIE_MIN;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
endmodule

// File: rtl/dice_game_ctrl.sv
// Two-player dice game controller: alternating throws, round evaluation, win/draw detection.
// Tie behaviour: define DICE_TIE_REROLL_EN to make a tie a scoreless re-roll round.
module dice_game_ctrl
    import dice_pkg::*;
#(
    parameter logic [3:0] WIN_SCORE = WIN_SCORE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             roll,
    input  logic             restart,
    output logic [3:0]       score1,
    output logic [3:0]       score2,
    output logic [DIE_W-1:0] die1,
    output logic [DIE_W-1:0] die2,
    output logic             turn,
    output logic             win1,
    output logic             win2,
    output logic             draw
);
    state_e           state_q;
    logic [3:0]       score1_q, score2_q;
    logic [3:0]       score1_d, score2_d;
    logic [DIE_W-1:0] die1_q, die2_q;
    logic             turn_q, win1_q, win2_q, draw_q;
    logic             p1_gets, p2_gets, hit1, hit2;
    logic             clear;
    logic [DIE_W-1:0] die_val;

    // restart is a full reset, including the die source
    assign clear = rst | restart;

    dice_rng u_rng (
        .clk   (clk),
        .rst   (clear),
        .value (die_val)
    );

    always_comb begin
        p1_gets = (die1_q > die2_q);
        p2_gets = (die2_q > die1_q);
`ifdef DICE_TIE_REROLL_EN
`else
        if (die1_q == die2_q) begin
            p1_gets = 1'b1;
            p2_gets = 1'b1;
        end
`endif
        score1_d = score1_q;
        score2_d = score2_q;
        if (p1_gets && (score1_q < WIN_SCORE)) score1_d = score1_q + 4'd1;
        if (p2_gets && (score2_q < WIN_SCORE)) score2_d = score2_q + 4'd1;
        hit1 = p1_gets && (score1_d == WIN_SCORE);
        hit2 = p2_gets && (score2_d == WIN_SCORE);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q  <= WAIT_P1;
            score1_q <= '0;
            score2_q <= '0;
            die1_q   <= '0;
            die2_q   <= '0;
            turn_q   <= 1'b0;
            win1_q   <= 1'b0;
            win2_q   <= 1'b0;
            draw_q   <= 1'b0;
        end else begin
            case (state_q)
                WAIT_P1: begin
                    if (roll) begin
                        die1_q  <= die_val;
                        die2_q  <= '0;
                        turn_q  <= 1'b1;
                        state_q <= WAIT_P2;
                    end
                end
                WAIT_P2: begin
                    if (roll) begin
                        die2_q  <= die_val;
                        turn_q  <= 1'b0;
                        state_q <= EVAL;
                    end
                end
                EVAL: begin
                    score1_q <= score1_d;
                    score2_q <= score2_d;
                    // simultaneous arrival is a draw, never a double win
                    draw_q   <= hit1 & hit2;
                    win1_q   <= hit1 & ~hit2;
                    win2_q   <= hit2 & ~hit1;
                    state_q  <= (hit1 | hit2) ? OVER : WAIT_P1;
                end
                OVER: begin
                    state_q <= OVER;
                end
                default: begin
                    state_q <= WAIT_P1;
                end
            endcase
        end
    end

    assign score1 = score1_q;
    assign score2 = score2_q;
    assign die1   = die1_q;
    assign die2   = die2_q;
    assign turn   = turn_q;
    assign win1   = win1_q;
    assign win2   = win2_q;
    assign draw   = draw_q;
endmodule

// File: tb/tb_dice_game_ctrl.sv
// Bench for dice_game_ctrl: three instances (WIN_SCORE 9, 2, 1) on shared stimulus,
// checked by a vector table, directed rounds and a randomized run against a game model.
module tb_dice_game_ctrl;
`ifdef DICE_TIE_REROLL_EN
    localparam bit REROLL = 1'b1;
`else
    localparam bit REROLL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic roll = 1'b0;
    logic restart = 1'b0;
    always #5 clk = ~clk;

    // packed view: {score1, score2, die1, die2, turn, win1, win2, draw}
    logic [17:0] obs [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        logic [3:0] s1, s2;
        logic [2:0] d1, d2;
        logic t, w1, w2, dr;
        dice_game_ctrl #(
            .WIN_SCORE(gi == 0 ? 4'd9 : (gi == 1 ? 4'd2 : 4'd1))
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .roll    (roll),
            .restart (restart),
            .score1  (s1),
            .score2  (s2),
            .die1    (d1),
            .die2    (d2),
            .turn    (t),
            .win1    (w1),
            .win2    (w2),
            .draw    (dr)
        );
        assign obs[gi] = {s1, s2, d1, d2, t, w1, w2, dr};
    end

    int checks = 0;
    int errors = 0;

    // game model: cycles since last reset, plus per-instance game record
    int cnt = 0;
    int win_v [3] = '{9, 2, 1};
    int m_s1 [3], m_s2 [3], m_d1 [3], m_d2 [3], m_ph [3];
    bit m_w1 [3], m_w2 [3], m_dr [3];

    function automatic logic [17:0] pk(int s1, int s2, int d1, int d2,
                                       int t, int w1, int w2, int dr);
        return {4'(s1), 4'(s2), 3'(d1), 3'(d2), 1'(t), 1'(w1), 1'(w2), 1'(dr)};
    endfunction

    task automatic check(input string nm, input logic [17:0] act, input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_update(input int i, input bit clr, input bit ro, input int dv);
        bit g1, g2, r1, r2;
        int n1, n2;
        if (clr) begin
            m_s1[i] = 0; m_s2[i] = 0; m_d1[i] = 0; m_d2[i] = 0; m_ph[i] = 0;
            m_w1[i] = 0; m_w2[i] = 0; m_dr[i] = 0;
        end else if (m_ph[i] == 0) begin
            if (ro) begin m_d1[i] = dv; m_d2[i] = 0; m_ph[i] = 1; end
        end else if (m_ph[i] == 1) begin
            if (ro) begin m_d2[i] = dv; m_ph[i] = 2; end
        end else if (m_ph[i] == 2) begin
            g1 = (m_d1[i] > m_d2[i]) || (m_d1[i] == m_d2[i] && !REROLL);
            g2 = (m_d2[i] > m_d1[i]) || (m_d1[i] == m_d2[i] && !REROLL);
            n1 = m_s1[i] + int'(g1); if (n1 > win_v[i]) n1 = win_v[i];
            n2 = m_s2[i] + int'(g2); if (n2 > win_v[i]) n2 = win_v[i];
            r1 = g1 && (n1 == win_v[i]);
            r2 = g2 && (n2 == win_v[i]);
            m_s1[i] = n1; m_s2[i] = n2;
            m_dr[i] = r1 && r2;
            m_w1[i] = r1 && !r2;
            m_w2[i] = r2 && !r1;
            m_ph[i] = (r1 || r2) ? 3 : 0;
        end
    endtask

    task automatic step(input logic r, input logic rs, input logic ro);
        int dv;
        rst = r; restart = rs; roll = ro;
        @(posedge clk);
        #1;
        dv = (cnt % 6) + 1;
        if (r || rs) cnt = 0; else cnt++;
        for (int i = 0; i < 3; i++) begin
            model_update(i, r || rs, ro, dv);
            check($sformatf("model_inst%0d", i), obs[i],
                  pk(m_s1[i], m_s2[i], m_d1[i], m_d2[i], int'(m_ph[i] == 1),
                     int'(m_w1[i]), int'(m_w2[i]), int'(m_dr[i])));
        end
        rst = 1'b0; restart = 1'b0; roll = 1'b0;
    endtask

    task automatic roll_at(input int v);
        while ((cnt % 6) + 1 != v) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic round(input int v1, input int v2);
        roll_at(v1);
        roll_at(v2);
        step(1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic        rst;
        logic        restart;
        logic        roll;
        logic [17:0] exp;
    } vec_t;

    vec_t tbl [13];
    int tie;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0)};
        for (int i = 1; i <= 4; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, pk(0, 0, 5, 0, 1, 0, 0, 0)};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, pk(0, 0, 5, 0, 1, 0, 0, 0)};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, pk(0, 0, 5, 0, 1, 0, 0, 0)};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, pk(0, 0, 5, 2, 0, 0, 0, 0)};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, pk(1, 0, 5, 2, 0, 0, 0, 0)};
        tbl[10] = '{1'b0, 1'b0, 1'b1, pk(1, 0, 4, 0, 1, 0, 0, 0)};
        tbl[11] = '{1'b0, 1'b1, 1'b1, pk(0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[12] = '{1'b0, 1'b0, 1'b1, pk(0, 0, 1, 0, 1, 0, 0, 0)};

        for (int r = 0; r < 13; r++) begin
            step(tbl[r].rst, tbl[r].restart, tbl[r].roll);
            check($sformatf("vec%0d", r), obs[0], tbl[r].exp);
        end

        // tie 4/4: both scores advance unless ties are re-rolled
        tie = REROLL ? 0 : 1;
        step(1'b0, 1'b1, 1'b0);
        round(4, 4);
        check("tie_scores", {10'd0, obs[0][17:10]}, {10'd0, 4'(tie), 4'(tie)});
        check("tie_win1_inst", obs[2],
              REROLL ? pk(0, 0, 4, 4, 0, 0, 0, 0) : pk(1, 1, 4, 4, 0, 0, 0, 1));

        // P2 wins twice at WIN_SCORE=2, then rolls in OVER are ignored
        step(1'b0, 1'b1, 1'b0);
        round(1, 6);
        round(2, 5);
        check("p2_win", obs[1], pk(0, 2, 2, 5, 0, 0, 1, 0));
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
        check("over_frozen", obs[1], pk(0, 2, 2, 5, 0, 0, 1, 0));

        // restart beats roll in WAIT_P2 with score1=3
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) round(6, 1);
        check("score1_three", {14'd0, obs[0][17:14]}, 18'd3);
        roll_at(6);
        check("p1_waiting", obs[0], pk(3, 0, 6, 0, 1, 0, 0, 0));
        step(1'b0, 1'b1, 1'b1);
        check("restart_roll", obs[0], pk(0, 0, 0, 0, 0, 0, 0, 0));
        check("restart_die2", {15'd0, obs[0][6:4]}, 18'd0);

        for (int i = 0; i < 500; i++) begin
            step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 2) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
